// File: rtl/freq_selector_pkg.sv
// Shared definitions for the frequency selector ring reader: word width, FSM states, minimum dwell.
package freq_selector_pkg;

    localparam int FREQ_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Shortest dwell that still leaves room to issue a prefetch and see its data before expiry.
    function automatic int min_dwell(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/freq_dwell_timer.sv
// Dwell down-counter for the ring reader; flags the prefetch point and the terminal count.
module freq_dwell_timer #(
    parameter int DWELL_W    = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic               dev_clk,
    input  logic               dev_rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    input  logic               stop,
    output logic               expire,
    output logic               prefetch
);
    import freq_selector_pkg::*;

    localparam logic [DWELL_W-1:0] PF_CNT = DWELL_W'(min_dwell(RD_LATENCY) - 1);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (stop) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (load) begin
            cnt_d    = value;
            active_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign expire   = active_q && (cnt_q == '0);
    assign prefetch = active_q && (cnt_q == PF_CNT);

endmodule

// File: rtl/freq_ring_reader.sv
// Paced reader of the tone ring: primes the first word, holds each tone for a dwell, prefetches the next.
// Optional FREQ_RING_READER_LOOP_EN adds cfg_loop for continuously wrapping sweeps.
//
// state | meaning
// IDLE  | waiting for start; freq_out held
// PRIME | first ring read issued, waiting for its data
// RUN   | tone held for the dwell; next word prefetched ahead of expiry
module freq_ring_reader #(
    parameter int FREQ_W     = freq_selector_pkg::FREQ_W,
    parameter int NUM_W      = 10,
    parameter int DWELL_W    = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic               dev_clk,
    input  logic               dev_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_W-1:0]   cfg_num,
    input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef FREQ_RING_READER_LOOP_EN
    input  logic               cfg_loop,
`endif
    output logic               rd_en_ring,
    input  logic [FREQ_W-1:0]  ring_din,
    output logic [FREQ_W-1:0]  freq_out,
    output logic               freq_strobe,
    output logic [NUM_W-1:0]   tone_idx,
    output logic               busy,
    output logic               sweep_done
);
    import freq_selector_pkg::*;

    localparam int MIN_DWELL = min_dwell(RD_LATENCY);

    state_e                state_q, state_d;
    logic [NUM_W-1:0]      last_idx_q, last_idx_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  loop_q, loop_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic                  rd_en_q, rd_en_d;
    logic [FREQ_W-1:0]     freq_q, freq_d;
    logic                  strobe_q, strobe_d;
    logic [NUM_W-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic tmr_load, tmr_clr, tmr_expire, tmr_prefetch;
    logic loop_cfg, data_valid, last_tone;

`ifdef FREQ_RING_READER_LOOP_EN
    assign loop_cfg = cfg_loop;
`else
    assign loop_cfg = 1'b0;
`endif

    assign data_valid = pipe_q[RD_LATENCY-1];
    assign last_tone  = (idx_q == last_idx_q);

    freq_dwell_timer #(
        .DWELL_W    (DWELL_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_timer (
        .dev_clk  (dev_clk),
        .dev_rst  (dev_rst),
        .load     (tmr_load),
        .value    (dwell_q),
        .stop     (tmr_clr),
        .expire   (tmr_expire),
        .prefetch (tmr_prefetch)
    );

    always_comb begin
        state_d    = state_q;
        last_idx_d = last_idx_q;
        dwell_d    = dwell_q;
        loop_d     = loop_q;
        pipe_d     = RD_LATENCY'({pipe_q, rd_en_q});
        rd_en_d    = 1'b0;
        freq_d     = freq_q;
        strobe_d   = 1'b0;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (cfg_num != '0)) begin
                    last_idx_d = cfg_num - 1'b1;
                    dwell_d    = (cfg_dwell < DWELL_W'(MIN_DWELL)) ? DWELL_W'(MIN_DWELL - 1)
                                                                   : cfg_dwell - 1'b1;
                    loop_d     = loop_cfg;
                    rd_en_d    = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = PRIME;
                end
            end
            PRIME: begin
                if (data_valid) begin
                    freq_d   = ring_din;
                    strobe_d = 1'b1;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (tmr_prefetch && (!last_tone || loop_q)) begin
                    rd_en_d = 1'b1;
                end
                if (tmr_expire) begin
                    if (!last_tone || loop_q) begin
                        freq_d   = ring_din;
                        strobe_d = 1'b1;
                        idx_d    = last_tone ? '0 : idx_q + 1'b1;
                        tmr_load = 1'b1;
                        done_d   = last_tone;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tmr_clr = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a tone update landing this cycle.
        if (stop) begin
            state_d    = IDLE;
            last_idx_d = last_idx_q;
            dwell_d    = dwell_q;
            loop_d     = loop_q;
            pipe_d     = '0;
            rd_en_d    = 1'b0;
            freq_d     = freq_q;
            strobe_d   = 1'b0;
            idx_d      = idx_q;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            tmr_load   = 1'b0;
            tmr_clr    = 1'b1;
        end
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            state_q    <= IDLE;
            last_idx_q <= '0;
            dwell_q    <= '0;
            loop_q     <= 1'b0;
            pipe_q     <= '0;
            rd_en_q    <= 1'b0;
            freq_q     <= '0;
            strobe_q   <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            dwell_q    <= dwell_d;
            loop_q     <= loop_d;
            pipe_q     <= pipe_d;
            rd_en_q    <= rd_en_d;
            freq_q     <= freq_d;
            strobe_q   <= strobe_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_en_ring  = rd_en_q;
    assign freq_out    = freq_q;
    assign freq_strobe = strobe_q;
    assign tone_idx    = idx_q;
    assign busy        = busy_q;
    assign sweep_done  = done_q;

endmodule

// File: tb/tb_freq_ring_reader.sv
// Bench for freq_ring_reader: schedule-based sweep model checked every cycle, plus directed literal cases.
module tb_freq_ring_reader;
    localparam int FREQ_W = 14;
    localparam int NUM_W  = 10;
    localparam int DWELL_W = 16;
    localparam int L      = 1;
    localparam int NEVER  = 32'h7fff_ffff;

    logic               dev_clk = 1'b0;
    logic               dev_rst, start, stop;
    logic [NUM_W-1:0]   cfg_num;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               rd_en_ring;
    logic [FREQ_W-1:0]  ring_din = '0;
    logic [FREQ_W-1:0]  freq_out;
    logic               freq_strobe;
    logic [NUM_W-1:0]   tone_idx;
    logic               busy, sweep_done;
`ifdef FREQ_RING_READER_LOOP_EN
    logic               cfg_loop = 1'b0;
`endif

    freq_ring_reader #(
        .FREQ_W(FREQ_W), .NUM_W(NUM_W), .DWELL_W(DWELL_W), .RD_LATENCY(L)
    ) dut (
        .dev_clk     (dev_clk),
        .dev_rst     (dev_rst),
        .start       (start),
        .stop        (stop),
        .cfg_num     (cfg_num),
        .cfg_dwell   (cfg_dwell),
`ifdef FREQ_RING_READER_LOOP_EN
        .cfg_loop    (cfg_loop),
`endif
        .rd_en_ring  (rd_en_ring),
        .ring_din    (ring_din),
        .freq_out    (freq_out),
        .freq_strobe (freq_strobe),
        .tone_idx    (tone_idx),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    always #5 dev_clk = ~dev_clk;

    // ring environment: one-cycle read latency
    logic [FREQ_W-1:0] ring_mem [64];
    int ring_ptr = 0;
    always @(posedge dev_clk) begin
        if (rd_en_ring) begin
            ring_din <= ring_mem[ring_ptr % 64];
            ring_ptr <= ring_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge dev_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // sweep model: one active sweep described by its start cycle and config
    bit                sw_valid = 0;
    int                sw_t, sw_num, sw_eff, sw_base;
    int                sw_abort = NEVER;
    int                rd_count = 0;
    logic [FREQ_W-1:0] exp_freq = '0;
    int                exp_idx  = 0;

    int lg_strobe[$];
    int lg_done[$];
    int lg_rd[$];
    logic [FREQ_W-1:0] lg_freq[$];

    always @(negedge dev_clk) begin
        int c, u0, dn, k;
        bit e_rd, e_st, e_bz, e_dn;
        c = cyc;
        e_rd = 0; e_st = 0; e_bz = 0; e_dn = 0;
        dn = NEVER;
        if (sw_valid) begin
            u0 = sw_t + 2 + L;
            dn = u0 + sw_num * sw_eff;
            if (c <= sw_abort) begin
                if (c == sw_t + 1) e_rd = 1;
                for (int j = 1; j < sw_num; j++)
                    if (c == u0 + j * sw_eff - 1 - L) e_rd = 1;
                if (c >= u0 && ((c - u0) % sw_eff) == 0 && ((c - u0) / sw_eff) < sw_num) begin
                    k = (c - u0) / sw_eff;
                    e_st = 1;
                    exp_freq = ring_mem[(sw_base + k) % 64];
                    exp_idx  = k;
                end
                e_bz = (c >= sw_t + 1) && (c < dn);
                e_dn = (c == dn);
            end
        end
        if (c >= 1) begin
            chk("rd_en_ring", 32'(rd_en_ring), 32'(e_rd));
            chk("freq_strobe", 32'(freq_strobe), 32'(e_st));
            chk("busy", 32'(busy), 32'(e_bz));
            chk("sweep_done", 32'(sweep_done), 32'(e_dn));
            chk("freq_out", 32'(freq_out), 32'(exp_freq));
            chk("tone_idx", 32'(tone_idx), 32'(exp_idx));
            if (freq_strobe === 1'b1) begin lg_strobe.push_back(c); lg_freq.push_back(freq_out); end
            if (sweep_done === 1'b1) lg_done.push_back(c);
            if (rd_en_ring === 1'b1) lg_rd.push_back(c);
        end
        if (e_rd) rd_count++;
        if (dev_rst) begin
            sw_valid = 0;
            exp_freq = '0;
            exp_idx  = 0;
        end else if (stop) begin
            if (sw_valid && c < dn && c < sw_abort) sw_abort = c;
        end else if (start && !e_bz && cfg_num != 0) begin
            sw_valid = 1;
            sw_t     = c;
            sw_num   = int'(cfg_num);
            sw_eff   = (int'(cfg_dwell) < L + 2) ? L + 2 : int'(cfg_dwell);
            sw_base  = rd_count;
            sw_abort = NEVER;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge dev_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        lg_strobe.delete(); lg_done.delete(); lg_rd.delete(); lg_freq.delete();
    endtask

    task automatic pulse_start(input int num, input int dwell, output int t);
        cfg_num = NUM_W'(num);
        cfg_dwell = DWELL_W'(dwell);
        start = 1;
        t = cyc;
        tick(1);
        start = 0;
    endtask

    task automatic chk_seq(input string nm, input int got[$], input int t, input int exp[$]);
        chk({nm, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk(nm, 32'(got[i] - t), 32'(exp[i]));
    endtask

    task automatic place_words(input logic [FREQ_W-1:0] w0, input logic [FREQ_W-1:0] w1,
                               input logic [FREQ_W-1:0] w2);
        ring_mem[ring_ptr % 64]       = w0;
        ring_mem[(ring_ptr + 1) % 64] = w1;
        ring_mem[(ring_ptr + 2) % 64] = w2;
    endtask

    initial begin
        int t, r, len;
        int eq[$];
        for (int i = 0; i < 64; i++) ring_mem[i] = FREQ_W'($urandom);
        dev_rst = 1; start = 0; stop = 0; cfg_num = '0; cfg_dwell = '0;
        tick(3);
        dev_rst = 0;
        tick(2);

        // basic sweep: updates at +3/+8/+13, done at +18
        place_words(14'h0100, 14'h0200, 14'h3FFF);
        clear_logs();
        pulse_start(3, 5, t);
        tick(24);
        eq = {3, 8, 13};  chk_seq("basic_strobe", lg_strobe, t, eq);
        eq = {18};        chk_seq("basic_done", lg_done, t, eq);
        eq = {1, 6, 11};  chk_seq("basic_rd", lg_rd, t, eq);
        if (lg_freq.size() == 3) begin
            chk("basic_w0", 32'(lg_freq[0]), 32'h0100);
            chk("basic_w1", 32'(lg_freq[1]), 32'h0200);
            chk("basic_w2", 32'(lg_freq[2]), 32'h3FFF);
        end
        chk("basic_hold", 32'(freq_out), 32'h3FFF);

        // dwell clamp: spacing 3
        place_words(14'h0011, 14'h0022, 14'h0033);
        clear_logs();
        pulse_start(3, 1, t);
        tick(16);
        eq = {3, 6, 9};   chk_seq("clamp_strobe", lg_strobe, t, eq);
        eq = {12};        chk_seq("clamp_done", lg_done, t, eq);
        eq = {1, 4, 7};   chk_seq("clamp_rd", lg_rd, t, eq);

        // abort while the second word is in flight
        place_words(14'h0ABC, 14'h1555, 14'h2AAA);
        clear_logs();
        pulse_start(3, 5, t);
        tick(6);
        stop = 1;
        tick(1);
        stop = 0;
        @(negedge dev_clk);
        chk("abort_busy", 32'(busy), 32'h0);
        tick(12);
        eq = {3};         chk_seq("abort_strobe", lg_strobe, t, eq);
        eq = {1, 6};      chk_seq("abort_rd", lg_rd, t, eq);
        chk("abort_done_count", 32'(lg_done.size()), 32'h0);
        chk("abort_hold", 32'(freq_out), 32'h0ABC);

        // zero tone count is ignored
        clear_logs();
        pulse_start(0, 4, t);
        tick(8);
        chk("zero_rd_count", 32'(lg_rd.size()), 32'h0);
        chk("zero_busy", 32'(busy), 32'h0);

        // start while busy is ignored
        place_words(14'h0101, 14'h0202, 14'h0303);
        clear_logs();
        pulse_start(2, 4, t);
        tick(3);
        cfg_num = NUM_W'(5);
        cfg_dwell = DWELL_W'(9);
        start = 1;
        tick(1);
        start = 0;
        tick(10);
        eq = {3, 7};      chk_seq("busy_start_strobe", lg_strobe, t, eq);
        eq = {11};        chk_seq("busy_start_done", lg_done, t, eq);

        // reset mid-RUN clears every output on the next edge
        place_words(14'h1234, 14'h2345, 14'h3456);
        pulse_start(3, 6, t);
        tick(6);
        dev_rst = 1;
        tick(1);
        dev_rst = 0;
        @(negedge dev_clk);
        chk("rst_freq", 32'(freq_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rd", 32'(rd_en_ring), 32'h0);
        chk("rst_idx", 32'(tone_idx), 32'h0);
        tick(3);

        // randomized sweeps with stray starts, stops and resets
        repeat (60) begin
            cfg_num = NUM_W'($urandom_range(0, 5));
            cfg_dwell = DWELL_W'($urandom_range(0, 8));
            start = 1;
            tick(1);
            start = 0;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 99);
                stop = (r < 4);
                start = (r >= 4 && r < 10);
                dev_rst = (r == 10);
                if (start) begin
                    cfg_num = NUM_W'($urandom_range(0, 5));
                    cfg_dwell = DWELL_W'($urandom_range(0, 8));
                end
                tick(1);
            end
            stop = 0; start = 0; dev_rst = 0;
        end
        tick(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
